// File: rtl/switch_reader.sv
// switch_reader: memory-mapped user switch input port.
// Synchronises and debounces WIDTH raw switches and latches per-bit change events
// in a W1C pending register. A level interrupt is raised for unmasked pending bits.
// Register map (word address): 0 STATE (RO), 1 PENDING (W1C), 2 MASK (RW), 3 RAW (RO).

// Per-switch debouncer: a change is accepted once the synchronised input has
// differed from the accepted state for STABLE_TICKS consecutive sample ticks.
module sw_debounce #(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic state,
  output logic accept
);
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt;

  // One-cycle pulse in the cycle the new level is committed; drives pending set.
  assign accept = tick && (din != state) && (cnt == LAST);

  // Count consecutive differing ticks; any agreeing tick restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (tick) begin
      if (din == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module switch_reader #(
  parameter int WIDTH        = 16,
  parameter int TICK_CYCLES  = 50000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] user_sw,
  input  logic [1:0]       Addr,
  input  logic             Re,
  input  logic             We,
  input  logic [15:0]      Din,
  output logic [15:0]      Dout,
  output logic             Irq
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] state, set, pending, mask, clr;
  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [15:0]      rdata;

  // Two-flop synchroniser; user_sw is fully asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= user_sw;
      sync2 <= sync1;
    end
  end

  // Free-running sample prescaler; tick marks the last count of each interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pcnt <= '0;
    else if (pcnt == PLAST) pcnt <= '0;
    else                  pcnt <= pcnt + 1'b1;
  end

  assign tick = (pcnt == PLAST);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      sw_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .din    (sync2[i]),
        .state  (state[i]),
        .accept (set[i])
      );
    end
  endgenerate

  assign clr = (We && Addr == 2'd1) ? Din[WIDTH-1:0] : '0;

  // Pending: a new change event beats a same-cycle W1C clear of that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr) | set;
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      mask <= '0;
    else if (We && Addr == 2'd2)  mask <= Din[WIDTH-1:0];
  end

  // Read mux over current (pre-write) register values, zero-extended.
  always_comb begin
    rdata = '0;
    case (Addr)
      2'd0:    rdata[WIDTH-1:0] = state;
      2'd1:    rdata[WIDTH-1:0] = pending;
      2'd2:    rdata[WIDTH-1:0] = mask;
      default: rdata[WIDTH-1:0] = sync2;
    endcase
  end

  // Registered read data (holds between reads) and registered level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Dout <= '0;
      Irq  <= 1'b0;
    end else begin
      if (Re) Dout <= rdata;
      Irq <= |(pending & mask);
    end
  end
endmodule
